// File: rtl/demux_rr_scheduler_if.sv
// rtl/demux_rr_scheduler_if.sv - request/grant bundle between requesters and the demux scheduler
interface demux_rr_scheduler_if #(
    parameter int HOLD_W = 4
);
    logic [3:0]        req;
    logic [HOLD_W-1:0] hold_len;
    logic [1:0]        select;
    logic              enable;
    logic [3:0]        grant;
    logic              busy;
    logic              done;

    // Requester side: raises requests and programs the dwell length
    modport master (
        output req,
        output hold_len,
        input  select,
        input  enable,
        input  grant,
        input  busy,
        input  done
    );

    // Scheduler side: consumes requests and drives the demux controls
    modport slave (
        input  req,
        input  hold_len,
        output select,
        output enable,
        output grant,
        output busy,
        output done
    );
endinterface

// File: rtl/demux_rr_scheduler.sv
// rtl/demux_rr_scheduler.sv - round-robin break-before-make scheduler for a 1x4 demux
module demux_rr_scheduler #(
    parameter int HOLD_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    demux_rr_scheduler_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACTIVE = 2'd2,
        GAP    = 2'd3
    } state_t;

    localparam logic [HOLD_W-1:0] CNT_ONE = {{(HOLD_W-1){1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic [1:0]        sel_q, sel_d;
    logic [1:0]        last_q, last_d;
    logic [HOLD_W-1:0] cnt_q, cnt_d;
    logic              en_q, en_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic [3:0]        grant_q, grant_d;

    // Scan last+1 .. last+4 (mod 4); first requesting channel wins, so the
    // last-served channel is only re-picked when nobody else asks.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] idx;
        logic       found;
        rr_pick = p;
        found   = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            idx = p + 2'(i);
            if (!found && r[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

    // Next-state and next-output decode; every output is computed here and
    // then registered so nothing on the bus is combinational from req
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        en_d    = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    sel_d   = rr_pick(bus.req, last_q);
                    state_d = SETUP;
                end
            end
            SETUP: begin
                cnt_d   = (bus.hold_len == '0) ? CNT_ONE : bus.hold_len;
                en_d    = 1'b1;
                state_d = ACTIVE;
            end
            ACTIVE: begin
                if (!bus.req[sel_q] || (cnt_q == CNT_ONE)) begin
                    done_d  = 1'b1;
                    state_d = GAP;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                    en_d  = 1'b1;
                end
            end
            GAP: begin
                last_d  = sel_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d  = (state_d != IDLE);
        grant_d = en_d ? (4'b0001 << sel_d) : 4'b0000;
    end

    // State and output registers; reset forces enable low immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= 2'd0;
            last_q  <= 2'd3;
            cnt_q   <= '0;
            en_q    <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            grant_q <= 4'b0000;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            en_q    <= en_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            grant_q <= grant_d;
        end
    end

    assign bus.select = sel_q;
    assign bus.enable = en_q;
    assign bus.grant  = grant_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;

endmodule

// File: tb/tb_demux_rr_scheduler.sv
// tb/tb_demux_rr_scheduler.sv - directed self-checking bench for demux_rr_scheduler
module tb_demux_rr_scheduler;

    logic clk;
    logic rst_n;

    demux_rr_scheduler_if #(.HOLD_W(4)) bus ();

    demux_rr_scheduler #(.HOLD_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [3:0] win_q[$];
    int         gap_q[$];
    int         en_cycles;
    int         done_cnt;
    int         sel_bad;
    int         first_en;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        bus.req      = 4'b0000;
        bus.hold_len = 4'd0;
        rst_n        = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    // Runs n cycles, recording each enable window's grant and the low gap before it
    task automatic run(input int n, input bit drop_on_done);
        logic       prev_en;
        logic [1:0] prev_sel;
        int         low_run;
        win_q.delete();
        gap_q.delete();
        en_cycles = 0;
        done_cnt  = 0;
        sel_bad   = 0;
        first_en  = -1;
        low_run   = 0;
        prev_en   = bus.enable;
        prev_sel  = bus.select;
        for (int i = 0; i < n; i++) begin
            step();
            if (bus.enable && !prev_en) begin
                win_q.push_back(bus.grant);
                gap_q.push_back(low_run);
            end
            if (bus.enable) begin
                en_cycles++;
                low_run = 0;
                if (first_en < 0) first_en = i + 1;
            end else begin
                low_run++;
            end
            if ((bus.select !== prev_sel) && (bus.enable || prev_en)) sel_bad++;
            if (bus.done) begin
                done_cnt++;
                if (drop_on_done) bus.req = 4'b0000;
            end
            prev_en  = bus.enable;
            prev_sel = bus.select;
        end
    endtask

    task automatic test_reset();
        apply_reset();
        total_cnt++;
        if ({bus.select, bus.enable, bus.grant, bus.busy, bus.done} !== 9'b0) begin
            $display("FAIL reset_outputs: got sel=%0d en=%0b grant=%b busy=%0b done=%0b, want all 0",
                     bus.select, bus.enable, bus.grant, bus.busy, bus.done);
        end else pass_cnt++;
    endtask

    task automatic test_single_grant();
        apply_reset();
        bus.req      = 4'b0001;
        bus.hold_len = 4'd3;
        step();
        total_cnt++;
        if (bus.select !== 2'd0 || bus.enable !== 1'b0 || bus.busy !== 1'b1) begin
            $display("FAIL single_setup: got sel=%0d en=%0b busy=%0b, want sel=0 en=0 busy=1",
                     bus.select, bus.enable, bus.busy);
        end else pass_cnt++;
        run(6, 1'b1);
        total_cnt++;
        if (first_en !== 1) $display("FAIL single_latency: enable first at %0d, want 1", first_en);
        else pass_cnt++;
        total_cnt++;
        if (en_cycles !== 3) $display("FAIL single_len: enable cycles %0d, want 3", en_cycles);
        else pass_cnt++;
        total_cnt++;
        if (win_q.size() !== 1 || win_q[0] !== 4'b0001)
            $display("FAIL single_grant: windows=%0d grant=%b, want 1 window grant=0001",
                     win_q.size(), (win_q.size() > 0) ? win_q[0] : 4'bxxxx);
        else pass_cnt++;
        total_cnt++;
        if (done_cnt !== 1) $display("FAIL single_done: done pulses %0d, want 1", done_cnt);
        else pass_cnt++;
        total_cnt++;
        if (bus.busy !== 1'b0) $display("FAIL single_idle_busy: busy=%0b, want 0", bus.busy);
        else pass_cnt++;
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_order [5];
        exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        apply_reset();
        bus.req      = 4'b1111;
        bus.hold_len = 4'd1;
        run(20, 1'b0);
        total_cnt++;
        if (win_q.size() !== 5) $display("FAIL rr_windows: got %0d windows, want 5", win_q.size());
        else pass_cnt++;
        for (int k = 0; k < 5; k++) begin
            total_cnt++;
            if (win_q.size() <= k || win_q[k] !== exp_order[k])
                $display("FAIL rr_order[%0d]: got %b, want %b", k,
                         (win_q.size() > k) ? win_q[k] : 4'bxxxx, exp_order[k]);
            else pass_cnt++;
        end
        for (int k = 1; k < 5; k++) begin
            total_cnt++;
            if (gap_q.size() <= k || gap_q[k] !== 3)
                $display("FAIL rr_gap[%0d]: got %0d low cycles, want 3", k,
                         (gap_q.size() > k) ? gap_q[k] : -1);
            else pass_cnt++;
        end
        total_cnt++;
        if (en_cycles !== 5) $display("FAIL rr_width: enable cycles %0d, want 5", en_cycles);
        else pass_cnt++;
        total_cnt++;
        if (sel_bad !== 0) $display("FAIL rr_bbm: select changed near enable %0d times, want 0", sel_bad);
        else pass_cnt++;
        bus.req = 4'b0000;
    endtask

    task automatic test_early_release();
        apply_reset();
        bus.req      = 4'b0100;
        bus.hold_len = 4'd8;
        step();
        step();
        step();
        total_cnt++;
        if (bus.enable !== 1'b1 || bus.grant !== 4'b0100)
            $display("FAIL early_active: en=%0b grant=%b, want en=1 grant=0100", bus.enable, bus.grant);
        else pass_cnt++;
        bus.req = 4'b0000;
        step();
        total_cnt++;
        if (bus.enable !== 1'b0 || bus.done !== 1'b1 || bus.grant !== 4'b0000)
            $display("FAIL early_gap: en=%0b done=%0b grant=%b, want en=0 done=1 grant=0000",
                     bus.enable, bus.done, bus.grant);
        else pass_cnt++;
        step();
        total_cnt++;
        if (dut.last_q !== 2'd2 || bus.busy !== 1'b0 || bus.done !== 1'b0)
            $display("FAIL early_last: last=%0d busy=%0b done=%0b, want last=2 busy=0 done=0",
                     dut.last_q, bus.busy, bus.done);
        else pass_cnt++;
    endtask

    task automatic test_hold_zero();
        apply_reset();
        bus.req      = 4'b0010;
        bus.hold_len = 4'd0;
        run(8, 1'b1);
        total_cnt++;
        if (en_cycles !== 1) $display("FAIL hold0_len: enable cycles %0d, want 1", en_cycles);
        else pass_cnt++;
        total_cnt++;
        if (win_q.size() !== 1 || win_q[0] !== 4'b0010)
            $display("FAIL hold0_grant: windows=%0d grant=%b, want 1 window grant=0010",
                     win_q.size(), (win_q.size() > 0) ? win_q[0] : 4'bxxxx);
        else pass_cnt++;
    endtask

    task automatic test_async_reset();
        apply_reset();
        bus.req      = 4'b0010;
        bus.hold_len = 4'd5;
        step();
        step();
        step();
        total_cnt++;
        if (bus.enable !== 1'b1) $display("FAIL arst_pre: en=%0b, want 1", bus.enable);
        else pass_cnt++;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (bus.enable !== 1'b0 || bus.grant !== 4'b0000 || bus.select !== 2'd0 || bus.busy !== 1'b0)
            $display("FAIL arst_immediate: en=%0b grant=%b sel=%0d busy=%0b, want all 0",
                     bus.enable, bus.grant, bus.select, bus.busy);
        else pass_cnt++;
        step();
        rst_n        = 1'b1;
        bus.req      = 4'b1000;
        bus.hold_len = 4'd2;
        run(8, 1'b1);
        total_cnt++;
        if (win_q.size() !== 1 || win_q[0] !== 4'b1000 || en_cycles !== 2)
            $display("FAIL arst_restart: windows=%0d grant=%b en_cycles=%0d, want 1 window grant=1000 en_cycles=2",
                     win_q.size(), (win_q.size() > 0) ? win_q[0] : 4'bxxxx, en_cycles);
        else pass_cnt++;
    endtask

    task automatic test_rr_after_serve();
        apply_reset();
        bus.req      = 4'b0100;
        bus.hold_len = 4'd1;
        run(5, 1'b1);
        total_cnt++;
        if (win_q.size() !== 1 || win_q[0] !== 4'b0100)
            $display("FAIL serve2_grant: windows=%0d grant=%b, want 1 window grant=0100",
                     win_q.size(), (win_q.size() > 0) ? win_q[0] : 4'bxxxx);
        else pass_cnt++;
        bus.req = 4'b0101;
        run(12, 1'b0);
        total_cnt++;
        if (win_q.size() < 2 || win_q[0] !== 4'b0001 || win_q[1] !== 4'b0100)
            $display("FAIL serve2_next: windows=%0d first=%b second=%b, want 0001 then 0100",
                     win_q.size(), (win_q.size() > 0) ? win_q[0] : 4'bxxxx,
                     (win_q.size() > 1) ? win_q[1] : 4'bxxxx);
        else pass_cnt++;
        bus.req = 4'b0000;
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.req      = 4'b0000;
        bus.hold_len = 4'd0;
        test_reset();
        test_single_grant();
        test_round_robin();
        test_early_release();
        test_hold_zero();
        test_async_reset();
        test_rr_after_serve();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
